// File: rtl/bip_control_unit_if.sv
// ---------------------------------------------------------------------------
// bip_control_unit_if
// Bundle between the BIP control unit and its environment (program memory,
// accumulator/ALU datapath, run control).
//
// Handshake: there is no valid/ready pair. start is a level request sampled
// on a rising clk edge only while the unit is idle or halted; opcode and
// operand are treated as valid in the EXEC cycle (synchronous program memory
// addressed by pc during FETCH). Every strobe is a single-cycle pulse.
//
// master : environment side (drives start/opcode/operand/acc flags)
// slave  : control unit side (drives pc, strobes, status, instr_count)
// ---------------------------------------------------------------------------
interface bip_control_unit_if #(
   parameter int PC_WIDTH     = 11,
   parameter int CNT_WIDTH    = 16,
   parameter int OPCODE_WIDTH = 5
);
   logic                    start;
   logic [OPCODE_WIDTH-1:0] opcode;
   logic [PC_WIDTH-1:0]     operand;
   logic                    acc_zero;
   logic                    acc_neg;
   logic [PC_WIDTH-1:0]     pc;
   logic [1:0]              SelA;
   logic                    SelB;
   logic                    WrAcc;
   logic [2:0]              AluOp;
   logic                    WrRam;
   logic                    RdRam;
   logic                    halted;
   logic                    illegal;
   logic [CNT_WIDTH-1:0]    instr_count;

   modport master (
      output start, opcode, operand, acc_zero, acc_neg,
      input  pc, SelA, SelB, WrAcc, AluOp, WrRam, RdRam, halted, illegal,
             instr_count
   );

   modport slave (
      input  start, opcode, operand, acc_zero, acc_neg,
      output pc, SelA, SelB, WrAcc, AluOp, WrRam, RdRam, halted, illegal,
             instr_count
   );
endinterface

// File: rtl/bip_control_unit.sv
// ---------------------------------------------------------------------------
// bip_control_unit
// Program counter, IDLE/FETCH/EXEC/HALT sequencer and opcode decode for the
// BIP datapath. One instruction every two clocks (FETCH then EXEC).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          bip_control_unit_if.slave (start, opcode, operand,
//                acc_zero, acc_neg in; pc, SelA, SelB, WrAcc, AluOp, WrRam,
//                RdRam, halted, illegal, instr_count out)
//   o_dbg_state  current sequencer state (debug visibility)
//
// Build option: define BIP_BRANCH_EN to decode opcodes 10000-10100 as
// BEQ/BNE/BMI/BPL/BRA. Without it those opcodes are illegal and pc only
// increments.
// ---------------------------------------------------------------------------
module bip_control_unit #(
   parameter int PC_WIDTH     = 11,
   parameter int CNT_WIDTH    = 16,
   parameter int OPCODE_WIDTH = 5
) (
   input  logic                clk,
   input  logic                rst,
   bip_control_unit_if.slave   bus,
   output logic [1:0]          o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(5'h00);
   localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(5'h01);
   localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(5'h02);
   localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(5'h03);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(5'h04);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5'h05);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(5'h06);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(5'h07);
   localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(5'h08);
   localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = OPCODE_WIDTH'(5'h09);
   localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(5'h0A);
   localparam logic [OPCODE_WIDTH-1:0] OP_ORI  = OPCODE_WIDTH'(5'h0B);
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(5'h0C);
   localparam logic [OPCODE_WIDTH-1:0] OP_XORI = OPCODE_WIDTH'(5'h0D);
`ifdef BIP_BRANCH_EN
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(5'h10);
   localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(5'h11);
   localparam logic [OPCODE_WIDTH-1:0] OP_BMI  = OPCODE_WIDTH'(5'h12);
   localparam logic [OPCODE_WIDTH-1:0] OP_BPL  = OPCODE_WIDTH'(5'h13);
   localparam logic [OPCODE_WIDTH-1:0] OP_BRA  = OPCODE_WIDTH'(5'h14);
`endif

   state_t               r_state;
   state_t               w_next_state;
   logic [PC_WIDTH-1:0]  r_pc;
   logic                 r_illegal;
   logic [CNT_WIDTH-1:0] r_cnt;

   logic [1:0]           w_sel_a;
   logic                 w_sel_b;
   logic                 w_wr_acc;
   logic [2:0]           w_alu_op;
   logic                 w_wr_ram;
   logic                 w_rd_ram;
   logic                 w_is_hlt;
   logic                 w_is_illegal;
`ifdef BIP_BRANCH_EN
   logic                 w_taken;
`else
   // Branch inputs have no consumer in this build.
   logic                 w_unused_branch;
   assign w_unused_branch = ^{bus.operand, bus.acc_zero, bus.acc_neg};
`endif

   // Decode is only active in EXEC, so strobes are zero in every other state.
   always_comb begin
      w_sel_a      = 2'b00;
      w_sel_b      = 1'b0;
      w_wr_acc     = 1'b0;
      w_alu_op     = 3'b000;
      w_wr_ram     = 1'b0;
      w_rd_ram     = 1'b0;
      w_is_hlt     = 1'b0;
      w_is_illegal = 1'b0;
`ifdef BIP_BRANCH_EN
      w_taken      = 1'b0;
`endif
      if (r_state == S_EXEC) begin
         case (bus.opcode)
            OP_HLT: w_is_hlt = 1'b1;
            OP_STO: w_wr_ram = 1'b1;
            OP_LD: begin
               w_wr_acc = 1'b1;
               w_rd_ram = 1'b1;
            end
            OP_LDI: begin
               w_sel_a  = 2'b01;
               w_wr_acc = 1'b1;
            end
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_ANDI,
            OP_OR, OP_ORI, OP_XOR, OP_XORI: begin
               // Odd opcodes in this range are the immediate forms.
               w_sel_a  = 2'b10;
               w_wr_acc = 1'b1;
               w_sel_b  = bus.opcode[0];
               w_rd_ram = ~bus.opcode[0];
               case (bus.opcode)
                  OP_ADD, OP_ADDI: w_alu_op = 3'b001;
                  OP_AND, OP_ANDI: w_alu_op = 3'b010;
                  OP_OR,  OP_ORI:  w_alu_op = 3'b011;
                  OP_XOR, OP_XORI: w_alu_op = 3'b100;
                  default:         w_alu_op = 3'b000;
               endcase
            end
`ifdef BIP_BRANCH_EN
            OP_BEQ: w_taken = bus.acc_zero;
            OP_BNE: w_taken = ~bus.acc_zero;
            OP_BMI: w_taken = bus.acc_neg;
            OP_BPL: w_taken = ~bus.acc_neg;
            OP_BRA: w_taken = 1'b1;
`endif
            default: w_is_illegal = 1'b1;
         endcase
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next_state = S_FETCH;
         S_FETCH: w_next_state = S_EXEC;
         S_EXEC:  w_next_state = (w_is_hlt || w_is_illegal) ? S_HALT : S_FETCH;
         S_HALT:  if (bus.start) w_next_state = S_FETCH;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_HALT && bus.start) begin
            r_pc      <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
         end else if (r_state == S_EXEC) begin
            if (w_is_illegal) begin
               r_illegal <= 1'b1;
            end else begin
               if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
               // HLT leaves pc on the halting instruction.
               if (!w_is_hlt) begin
`ifdef BIP_BRANCH_EN
                  r_pc <= w_taken ? bus.operand : r_pc + PC_WIDTH'(1);
`else
                  r_pc <= r_pc + PC_WIDTH'(1);
`endif
               end
            end
         end
      end
   end

   assign bus.pc          = r_pc;
   assign bus.SelA        = w_sel_a;
   assign bus.SelB        = w_sel_b;
   assign bus.WrAcc       = w_wr_acc;
   assign bus.AluOp       = w_alu_op;
   assign bus.WrRam       = w_wr_ram;
   assign bus.RdRam       = w_rd_ram;
   assign bus.halted      = (r_state == S_HALT);
   assign bus.illegal     = r_illegal;
   assign bus.instr_count = r_cnt;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_bip_control_unit.sv
// ---------------------------------------------------------------------------
// tb_bip_control_unit
// Bench for bip_control_unit: a program memory array feeds opcode/operand
// from pc, an instruction-level reference model predicts the (pc, strobes)
// pair of every EXEC cycle plus the final pc/count/illegal, and the run loop
// compares cycle by cycle. Directed programs plus randomized programs.
// ---------------------------------------------------------------------------
module tb_bip_control_unit;

   localparam int PW = 11;
   localparam int CW = 16;
   localparam int OW = 5;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   bip_control_unit_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW), .OPCODE_WIDTH(OW)) bus ();

   bip_control_unit #(.PC_WIDTH(PW), .CNT_WIDTH(CW), .OPCODE_WIDTH(OW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- program memory ----------------
   logic [OW-1:0] mem_op  [0:2047];
   logic [PW-1:0] mem_opd [0:2047];
   bit            fz [0:255];
   bit            fn [0:255];

   assign bus.opcode  = mem_op[bus.pc];
   assign bus.operand = mem_opd[bus.pc];

   // ---------------- scoreboard ----------------
   logic [19:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          exp_n;
   logic [PW-1:0] exp_pc;
   logic [CW-1:0] exp_cnt;
   logic          exp_ill;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [8:0] strobes_now();
      return {bus.SelA, bus.SelB, bus.WrAcc, bus.AluOp, bus.WrRam, bus.RdRam};
   endfunction

   // Reference strobe word {SelA,SelB,WrAcc,AluOp,WrRam,RdRam} per mnemonic.
   function automatic logic [8:0] ref_strobes(input logic [4:0] op);
      case (op)
         5'd1:        return 9'b00_0_0_000_1_0;  // STO
         5'd2:        return 9'b00_0_1_000_0_1;  // LD
         5'd3:        return 9'b01_0_1_000_0_0;  // LDI
         5'd4:        return 9'b10_0_1_001_0_1;  // ADD
         5'd5:        return 9'b10_1_1_001_0_0;  // ADDI
         5'd6:        return 9'b10_0_1_000_0_1;  // SUB
         5'd7:        return 9'b10_1_1_000_0_0;  // SUBI
         5'd8:        return 9'b10_0_1_010_0_1;  // AND
         5'd9:        return 9'b10_1_1_010_0_0;  // ANDI
         5'd10:       return 9'b10_0_1_011_0_1;  // OR
         5'd11:       return 9'b10_1_1_011_0_0;  // ORI
         5'd12:       return 9'b10_0_1_100_0_1;  // XOR
         5'd13:       return 9'b10_1_1_100_0_0;  // XORI
         default:     return 9'b0;               // HLT, branches, illegal
      endcase
   endfunction

   function automatic bit ref_legal(input logic [4:0] op);
`ifdef BIP_BRANCH_EN
      return (op <= 5'd13) || (op >= 5'd16 && op <= 5'd20);
`else
      return (op <= 5'd13);
`endif
   endfunction

   // Instruction-level execution of the program currently in memory.
   task automatic model_run();
      logic [PW-1:0] pc;
      logic [4:0]    op;
      bit            taken;
      pc = '0; exp_cnt = '0; exp_ill = 1'b0; exp_n = 0;
      exp_q.delete();
      while (exp_n < 200) begin
         op = mem_op[pc];
         exp_q.push_back({pc, ref_strobes(op)});
         taken = 1'b0;
`ifdef BIP_BRANCH_EN
         case (op)
            5'd16: taken = fz[exp_n];
            5'd17: taken = !fz[exp_n];
            5'd18: taken = fn[exp_n];
            5'd19: taken = !fn[exp_n];
            5'd20: taken = 1'b1;
            default: taken = 1'b0;
         endcase
`endif
         exp_n++;
         if (!ref_legal(op)) begin
            exp_ill = 1'b1;
            break;
         end
         if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         if (op == 5'd0) break;
         pc = taken ? mem_opd[pc] : pc + 11'd1;
      end
      exp_pc = pc;
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_mem();
      for (int i = 0; i < 2048; i++) begin
         mem_op[i]  = 5'd0;
         mem_opd[i] = '0;
      end
      for (int i = 0; i < 256; i++) begin
         fz[i] = 1'b0;
         fn[i] = 1'b0;
      end
   endtask

   task automatic put(input int addr, input logic [4:0] op, input logic [PW-1:0] opd);
      mem_op[addr]  = op;
      mem_opd[addr] = opd;
   endtask

   task automatic gen_random();
      int len;
      int r;
      clear_mem();
      len = $urandom_range(4, 12);
      for (int a = 0; a < len; a++) begin
         r = $urandom_range(0, 99);
         if (r < 6)
            put(a, 5'($urandom_range(21, 31)), 11'($urandom));
         else if (r < 30)
            put(a, 5'($urandom_range(16, 20)), 11'($urandom_range(a + 1, len)));
         else
            put(a, 5'($urandom_range(1, 13)), 11'($urandom));
      end
      put(len, 5'd0, '0);
      for (int i = 0; i < 256; i++) begin
         fz[i] = 1'($urandom);
         fn[i] = 1'($urandom);
      end
   endtask

   // Run the loaded program from IDLE/HALT; noise toggles start while running.
   task automatic run_prog(input string nm, input bit noise);
      int  cycles;
      int  halt_cyc;
      int  step;
      bit  done;
      logic [19:0] e;
      model_run();
      halt_cyc = 2 * exp_n + 1;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      cycles = 0;
      done   = 1'b0;
      while (!done) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            check({nm, "_start_pc"}, 32'(bus.pc), 32'd0);
            check({nm, "_start_ill"}, 32'(bus.illegal), 32'd0);
         end
         if (bus.halted) begin
            done = 1'b1;
         end else if (cycles > halt_cyc + 4) begin
            check({nm, "_timeout"}, 32'd1, 32'd0);
            done = 1'b1;
         end else begin
            if (cycles % 2 == 0 && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check({nm, "_exec"}, 32'({bus.pc, strobes_now()}), 32'(e));
            end else begin
               check({nm, "_idle_strb"}, 32'(strobes_now()), 32'd0);
               if (exp_q.size() > 0)
                  check({nm, "_fetch_pc"}, 32'(bus.pc), 32'(exp_q[0][19:9]));
            end
            @(posedge clk); #1;
            bus.start = (noise && (cycles + 1 < halt_cyc)) ? 1'($urandom) : 1'b0;
            if (cycles % 2 == 1) begin
               step = (cycles - 1) / 2;
               bus.acc_zero = fz[step % 256];
               bus.acc_neg  = fn[step % 256];
            end
         end
      end
      bus.start = 1'b0;
      check({nm, "_halt_cyc"}, 32'(cycles), 32'(halt_cyc));
      check({nm, "_halted"}, 32'(bus.halted), 32'd1);
      check({nm, "_halt_strb"}, 32'(strobes_now()), 32'd0);
      check({nm, "_pc"}, 32'(bus.pc), 32'(exp_pc));
      check({nm, "_cnt"}, 32'(bus.instr_count), 32'(exp_cnt));
      check({nm, "_ill"}, 32'(bus.illegal), 32'(exp_ill));
      check({nm, "_q_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_idle(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({nm, "_pc"}, 32'(bus.pc), 32'd0);
         check({nm, "_strb"}, 32'(strobes_now()), 32'd0);
         check({nm, "_halted"}, 32'(bus.halted), 32'd0);
         check({nm, "_ill"}, 32'(bus.illegal), 32'd0);
         check({nm, "_cnt"}, 32'(bus.instr_count), 32'd0);
      end
   endtask

   task automatic load_prog1();
      clear_mem();
      put(0, 5'd3, 11'd5);   // LDI 5
      put(1, 5'd5, 11'd3);   // ADDI 3
      put(2, 5'd1, 11'd7);   // STO 7
      put(3, 5'd0, 11'd0);   // HLT
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.acc_zero = 1'b0;
      bus.acc_neg = 1'b0;
      load_prog1();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_idle("reset", 3);

      // LDI/ADDI/STO/HLT
      run_prog("p1", 1'b0);
      check("p1_cnt4", 32'(bus.instr_count), 32'd4);
      check("p1_pc3", 32'(bus.pc), 32'd3);

      // Branch walk: BEQ taken, BEQ not taken, BRA to all-ones, wrap to 0.
      clear_mem();
      put(0,      5'd3,  11'd1);
      put(1,      5'd16, 11'h020);
      put(11'h20, 5'd16, 11'h100);
      put(11'h21, 5'd20, 11'h7FF);
      put(11'h7FF, 5'd5, 11'd1);
      put(2,      5'd0,  11'd0);
      fz[1] = 1'b1;
      run_prog("br", 1'b0);
`ifdef BIP_BRANCH_EN
      check("br_pc", 32'(bus.pc), 32'd2);
      check("br_cnt", 32'(bus.instr_count), 32'd8);
`else
      check("br_ill", 32'(bus.illegal), 32'd1);
      check("br_pc", 32'(bus.pc), 32'd1);
`endif

      // Illegal opcode at pc=4
      clear_mem();
      put(0, 5'd3, 11'd9);
      put(1, 5'd2, 11'd4);
      put(2, 5'd6, 11'd4);
      put(3, 5'd13, 11'h55);
      put(4, 5'd31, 11'd0);
      run_prog("ill", 1'b0);
      check("ill_flag", 32'(bus.illegal), 32'd1);
      check("ill_pc4", 32'(bus.pc), 32'd4);
      check("ill_cnt4", 32'(bus.instr_count), 32'd4);

      // Restart from HALT clears pc/illegal (checked at first FETCH).
      load_prog1();
      run_prog("restart", 1'b1);

      // Reset asserted mid-EXEC, held two cycles.
      model_run();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      check_idle("rst_exec", 3);

      // Run to HALT, then rst together with start: rst wins, stays IDLE.
      run_prog("pre_rs", 1'b0);
      @(posedge clk); #1 rst = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1 rst = 1'b0; bus.start = 1'b0;
      check_idle("rst_start", 3);

      // Randomized programs with start noise during run.
      for (int k = 0; k < 25; k++) begin
         gen_random();
         run_prog("rnd", 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Sequenced control unit for the BIP processor datapath: program counter, fetch/execute state machine and opcode decode in one block. It sits between the synchronous program memory and the datapath (accumulator, ALU, data RAM) and drives the datapath strobes one instruction at a time. It extends the combinational BIP-I decoder with these additions:
- parametrised PC, instruction-count and opcode widths;
- logic ALU operations;
- conditional and unconditional branches;
- an explicit run/halt state machine with illegal-opcode detection.

## Interface
Parameters:
- PC_WIDTH, 11, width of program counter and branch target operand
- CNT_WIDTH, 16, width of retired-instruction counter
- OPCODE_WIDTH, 5, opcode field width (must be ≥5)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request, sampled in IDLE and HALT only
- opcode  in  OPCODE_WIDTH  instruction opcode from program memory (valid in EXEC)
- operand  in  PC_WIDTH  instruction operand, used as branch target
- acc_zero  in  1  accumulator == 0
- acc_neg  in  1  accumulator MSB
- pc  out  PC_WIDTH  program-memory address
- SelA  out  2  accumulator input mux (00 RAM, 01 operand, 10 ALU)
- SelB  out  1  ALU B mux (0 RAM, 1 operand)
- WrAcc  out  1  accumulator write enable
- AluOp  out  3  ALU function: 000 SUB, 001 ADD, 010 AND, 011 OR, 100 XOR
- WrRam  out  1  data RAM write enable
- RdRam  out  1  data RAM read enable
- halted  out  1  high in HALT state
- illegal  out  1  sticky, set when an undefined opcode is executed
- instr_count  out  CNT_WIDTH  retired instructions since reset or restart

## Operation
- States:
  - IDLE → FETCH on start.
  - FETCH → EXEC unconditionally.
  - EXEC → FETCH for normal instructions.
  - EXEC → HALT on HLT or an illegal opcode.
  - HALT → FETCH on start.
- Restart from HALT: pc←0, illegal←0, instr_count←0.
- start while in FETCH or EXEC is ignored.
- Strobe outputs (SelA, SelB, WrAcc, AluOp, WrRam, RdRam) are nonzero only in EXEC. They are decoded combinationally from opcode and are all 0 in every other state.
- Opcodes (SelA / SelB / WrAcc / AluOp / WrRam / RdRam):
  - 00000 HLT: all 0.
  - 00001 STO: WrRam=1.
  - 00010 LD: SelA=00, WrAcc=1, RdRam=1.
  - 00011 LDI: SelA=01, WrAcc=1.
  - 00100 ADD: SelA=10, SelB=0, WrAcc=1, AluOp=001, RdRam=1.
  - 00101 ADDI: SelA=10, SelB=1, WrAcc=1, AluOp=001.
  - 00110 SUB: SelA=10, SelB=0, WrAcc=1, AluOp=000, RdRam=1.
  - 00111 SUBI: SelA=10, SelB=1, WrAcc=1, AluOp=000.
  - 01000 AND and 01001 ANDI, AluOp=010.
  - 01010 OR and 01011 ORI, AluOp=011.
  - 01100 XOR and 01101 XORI, AluOp=100.
  - For these six: the register forms use SelB=0 and RdRam=1; the immediate forms use SelB=1; all use SelA=10, WrAcc=1.
  - Branches (with BIP_BRANCH_EN): 10000 BEQ (taken if acc_zero), 10001 BNE (if !acc_zero), 10010 BMI (if acc_neg), 10011 BPL (if !acc_neg), 10100 BRA (always). All strobes 0.
  - Any other opcode is illegal: all strobes 0, illegal←1, go to HALT.
- PC update, at the end of EXEC only:
  - Taken branch: pc←operand.
  - Otherwise pc←pc+1, mod 2^PC_WIDTH (wraps from all-ones to 0).
  - HLT or illegal: pc holds and keeps pointing at the halting instruction.
- Branch flags are sampled in the EXEC cycle. They reflect the accumulator after the previous instruction's write.
- instr_count:
  - Increments at the end of every EXEC, including HLT, but not illegal opcodes.
  - Saturates at all-ones.

## Timing
- Reset (rst=1 at an edge), regardless of state: state=IDLE, pc=0, all strobes 0, halted=0, illegal=0, instr_count=0.
- Reset mid-instruction aborts the instruction. No strobe is asserted in the cycle after reset.
- Program memory is synchronous-read: pc is valid in FETCH and opcode/operand are valid in EXEC.
- CPI = 2. start high in IDLE at edge t gives:
  - FETCH in cycle t+1 (pc=0);
  - EXEC in cycle t+2, strobes for address 0;
  - FETCH in cycle t+3 with pc=1 or the branch target.
- Each strobe is high for exactly one clock per instruction.
- halted rises in the cycle after the EXEC of HLT. It falls the cycle after start is sampled in HALT.
- Simultaneous rst and start: rst wins.

## Configuration
- BIP_BRANCH_EN defined: opcodes 10000–10100 decode as branches as specified.
- BIP_BRANCH_EN undefined:
  - Opcodes 10000–10100 are illegal (halt, illegal=1).
  - acc_zero, acc_neg and operand are unused.
  - pc only increments.

## Test plan
- rst held 2 cycles, then released, in a mid-EXEC state → pc=0, strobes 0, state IDLE, illegal=0, instr_count=0.
- start; program LDI 5, ADDI 3, STO 7, HLT → strobe sequence matches the decode list, each strobe for one cycle; halted=1 at cycle 9 after start; instr_count=4; pc=3.
- BEQ operand 0x020 with acc_zero=1 → next fetch pc=0x020. With acc_zero=0 → pc=old+1. BRA 0x7FF → pc=0x7FF; the following instruction wraps pc to 0.
- Opcode 11111 at pc=4 → no strobes, illegal=1, halted=1, pc=4, instr_count unchanged; start → pc=0, illegal=0.
- start pulsed during RUN (FETCH and EXEC) → ignored. rst asserted together with start in HALT → IDLE, pc=0.
- Build without BIP_BRANCH_EN: BEQ → illegal=1, halted=1.
